// File: rtl/alu_bist.sv
// Built-in self-test engine for the ALU. It sweeps every ALU operation over four
// corner vectors and then LFSR vectors, and checks each response against an
// internal golden model. It counts mismatches and captures the first failure.
module alu_bist #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE12468,
    parameter int unsigned ERR_W       = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              start,
    output logic [31:0]       port_a,
    output logic [31:0]       port_b,
    output logic [3:0]        alu_op,
    input  logic [31:0]       result,
    input  logic              negative,
    input  logic              overflow,
    input  logic              zero,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [3:0]        fail_op,
    output logic [31:0]       fail_a,
    output logic [31:0]       fail_b
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned VEC_W  = 16;

    localparam logic [OP_W-1:0] ALU_SLL  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_NOR  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b1010;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b1011;

    localparam logic [WORD_W-1:0] LFSR_TAPS = 32'h80200003;
    localparam logic [WORD_W-1:0] B_MASK    = 32'h5A5A5A5A;
    localparam logic [VEC_W-1:0]  LAST_VEC  = VEC_W'(NUM_VECTORS - 1);
    localparam logic [VEC_W-1:0]  NUM_CORNER = VEC_W'(4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [VEC_W-1:0]  vec, vec_nxt;
    logic [WORD_W-1:0] lfsr, lfsr_nxt;

    logic [WORD_W-1:0] port_a_nxt, port_b_nxt;
    logic [OP_W-1:0]   alu_op_nxt;
    logic              busy_nxt, done_nxt, pass_nxt;
    logic [ERR_W-1:0]  err_count_nxt;
    logic [OP_W-1:0]   fail_op_nxt;
    logic [WORD_W-1:0] fail_a_nxt, fail_b_nxt;

    logic [WORD_W-1:0] exp_res;
    logic              exp_ovf;
    logic              chk_ovf;
    logic              mismatch_c;

    logic              last_vec_c;
    logic              final_c;
    logic [VEC_W-1:0]  nv_vec;
    logic [OP_W-1:0]   nv_op;
    logic [WORD_W-1:0] nv_a, nv_b, nv_lfsr;

    // Galois LFSR step, shifting right
    function automatic logic [WORD_W-1:0] lfsr_step(input logic [WORD_W-1:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : '0);
    endfunction

    // Fixed sweep order over the ALU operations
    function automatic logic [OP_W-1:0] next_op(input logic [OP_W-1:0] op);
        logic [OP_W-1:0] n;
        case (op)
            ALU_SLL: n = ALU_SRL;
            ALU_SRL: n = ALU_ADD;
            ALU_ADD: n = ALU_SUB;
            ALU_SUB: n = ALU_AND;
            ALU_AND: n = ALU_OR;
            ALU_OR:  n = ALU_XOR;
            ALU_XOR: n = ALU_NOR;
            ALU_NOR: n = ALU_SLT;
            default: n = ALU_SLTU;
        endcase
        return n;
    endfunction

    // Golden model of the vector currently driven onto the ALU
    always_comb begin
        exp_res = '0;
        exp_ovf = 1'b0;
        chk_ovf = 1'b0;
        case (alu_op)
            ALU_SLL:  exp_res = port_a << port_b[4:0];
            ALU_SRL:  exp_res = port_a >> port_b[4:0];
            ALU_ADD: begin
                exp_res = port_a + port_b;
                exp_ovf = (port_a[31] == port_b[31]) && (exp_res[31] != port_a[31]);
                chk_ovf = 1'b1;
            end
            ALU_SUB: begin
                exp_res = port_a - port_b;
                exp_ovf = (port_a[31] != port_b[31]) && (exp_res[31] != port_a[31]);
                chk_ovf = 1'b1;
            end
            ALU_AND:  exp_res = port_a & port_b;
            ALU_OR:   exp_res = port_a | port_b;
            ALU_XOR:  exp_res = port_a ^ port_b;
            ALU_NOR:  exp_res = ~(port_a | port_b);
            ALU_SLT:  exp_res = {31'd0, ($signed(port_a) < $signed(port_b))};
            ALU_SLTU: exp_res = {31'd0, (port_a < port_b)};
            default:  exp_res = '0;
        endcase
        mismatch_c = (result != exp_res)
                  || (negative != exp_res[31])
                  || (zero != (exp_res == '0))
                  || (chk_ovf && (overflow != exp_ovf));
    end

    // Next vector: corner table for the first four, LFSR-derived afterwards
    always_comb begin
        last_vec_c = (vec == LAST_VEC);
        final_c    = (state == S_RUN) && last_vec_c && (alu_op == ALU_SLTU);
        nv_vec     = last_vec_c ? '0 : vec + VEC_W'(1);
        nv_op      = last_vec_c ? next_op(alu_op) : alu_op;
        nv_lfsr    = last_vec_c ? SEED : lfsr;
        nv_a       = '0;
        nv_b       = '0;
        if (nv_vec >= NUM_CORNER) begin
            nv_a    = nv_lfsr;
            nv_b    = {nv_lfsr[15:0], nv_lfsr[31:16]} ^ B_MASK;
            nv_lfsr = lfsr_step(nv_lfsr);
        end else begin
            case (nv_vec[1:0])
                2'd0: begin nv_a = 32'h00000000; nv_b = 32'h00000000; end
                2'd1: begin nv_a = 32'hFFFFFFFF; nv_b = 32'h00000001; end
                2'd2: begin nv_a = 32'h7FFFFFFF; nv_b = 32'h00000001; end
                default: begin nv_a = 32'h80000000; nv_b = 32'hFFFFFFFF; end
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (final_c) state_nxt = S_DONE;
            S_DONE:  if (start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the datapath and status registers
    always_comb begin
        port_a_nxt    = port_a;
        port_b_nxt    = port_b;
        alu_op_nxt    = alu_op;
        vec_nxt       = vec;
        lfsr_nxt      = lfsr;
        busy_nxt      = busy;
        done_nxt      = done;
        pass_nxt      = pass;
        err_count_nxt = err_count;
        fail_op_nxt   = fail_op;
        fail_a_nxt    = fail_a;
        fail_b_nxt    = fail_b;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    port_a_nxt    = '0;
                    port_b_nxt    = '0;
                    alu_op_nxt    = ALU_SLL;
                    vec_nxt       = '0;
                    lfsr_nxt      = SEED;
                    busy_nxt      = 1'b1;
                    done_nxt      = 1'b0;
                    pass_nxt      = 1'b0;
                    err_count_nxt = '0;
                    fail_op_nxt   = '0;
                    fail_a_nxt    = '0;
                    fail_b_nxt    = '0;
                end
            end
            S_RUN: begin
                if (mismatch_c) begin
                    if (err_count != '1) begin
                        err_count_nxt = err_count + ERR_W'(1);
                    end
                    if (err_count == '0) begin
                        fail_op_nxt = alu_op;
                        fail_a_nxt  = port_a;
                        fail_b_nxt  = port_b;
                    end
                end
                if (final_c) begin
                    busy_nxt = 1'b0;
                    done_nxt = 1'b1;
                    pass_nxt = (err_count_nxt == '0);
                end else begin
                    port_a_nxt = nv_a;
                    port_b_nxt = nv_b;
                    alu_op_nxt = nv_op;
                    vec_nxt    = nv_vec;
                    lfsr_nxt   = nv_lfsr;
                end
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            port_a    <= '0;
            port_b    <= '0;
            alu_op    <= '0;
            vec       <= '0;
            lfsr      <= SEED;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_op   <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
        end else begin
            port_a    <= port_a_nxt;
            port_b    <= port_b_nxt;
            alu_op    <= alu_op_nxt;
            vec       <= vec_nxt;
            lfsr      <= lfsr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_count_nxt;
            fail_op   <= fail_op_nxt;
            fail_a    <= fail_a_nxt;
            fail_b    <= fail_b_nxt;
        end
    end

endmodule
